// File: rtl/example_pkg.sv
// Shared constants and index helper for the 4-input truth-table block.
// Defaults match the (x1&x2)|(x3&x4) function.
package example_pkg;

   localparam logic [15:0] EXAMPLE_DEFAULT_TT    = 16'hF888;
   localparam int          EXAMPLE_CNT_W_DEFAULT = 8;

   // x1 is the MSB of the lookup index, x4 the LSB.
   function automatic logic [3:0] idx4(input logic x1, input logic x2,
                                       input logic x3, input logic x4);
      return {x1, x2, x3, x4};
   endfunction

endpackage

// File: rtl/example_lut.sv
// Stateless 16-entry lookup: y = tt[idx]. Zero latency, no flow control.
module example_lut
   import example_pkg::*;
(
   input  logic [3:0]  idx,
   input  logic [15:0] tt,
   output logic        y
);

   assign y = tt[idx];

endmodule

// File: rtl/example.sv
// Truth-table function with registered copy, rising-edge pulse and saturating hit counter.
// f_comb is combinational; f/f_rise/hit_cnt have 1-cycle latency; no backpressure.
module example
   import example_pkg::*;
#(
   parameter logic [15:0] TRUTH_TABLE = EXAMPLE_DEFAULT_TT,
   parameter int          CNT_W       = EXAMPLE_CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x1,
   input  logic             x2,
   input  logic             x3,
   input  logic             x4,
   output logic             f_comb,
   output logic             f,
   output logic             f_rise,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0] idx;

   assign idx = idx4(x1, x2, x3, x4);

   example_lut u_lut (
      .idx (idx),
      .tt  (TRUTH_TABLE),
      .y   (f_comb)
   );

   // f_rise compares the value being loaded against the current f, so a 1 on
   // the first edge after reset release also pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f       <= 1'b0;
         f_rise  <= 1'b0;
         hit_cnt <= '0;
      end else begin
         f      <= f_comb;
         f_rise <= f_comb & ~f;
         if (f_comb && (hit_cnt != CNT_MAX)) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_example.sv
// Scoreboard bench for example: default table instance plus a 16'h0001 instance.
module tb_example;

   typedef struct {
      logic       f;
      logic       rise;
      logic [7:0] cnt;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       x1, x2, x3, x4;
   logic       f_comb, f, f_rise;
   logic [7:0] hit_cnt;
   logic       f_comb1, f1, f_rise1;
   logic [7:0] hit_cnt1;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   logic       m_f;
   logic [7:0] m_cnt;

   example u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .x1      (x1),
      .x2      (x2),
      .x3      (x3),
      .x4      (x4),
      .f_comb  (f_comb),
      .f       (f),
      .f_rise  (f_rise),
      .hit_cnt (hit_cnt)
   );

   example #(.TRUTH_TABLE(16'h0001), .CNT_W(8)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .x1      (x1),
      .x2      (x2),
      .x3      (x3),
      .x4      (x4),
      .f_comb  (f_comb1),
      .f       (f1),
      .f_rise  (f_rise1),
      .hit_cnt (hit_cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      m_f   = 1'b0;
      m_cnt = 8'd0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one vector at a negedge, check f_comb, predict and check the registered outputs.
   task automatic step(input logic [3:0] v, input string tag);
      exp_t e;
      logic c;
      {x1, x2, x3, x4} = v;
      #1;
      c = (v[3] & v[2]) | (v[1] & v[0]);
      checks++;
      if (f_comb !== c) begin
         errors++;
         $display("FAIL %s f_comb v=%b got=%b exp=%b", tag, v, f_comb, c);
      end
      e.f    = c;
      e.rise = c & ~m_f;
      e.cnt  = c ? ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1) : m_cnt;
      m_f    = e.f;
      m_cnt  = e.cnt;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (f !== e.f) begin
         errors++;
         $display("FAIL %s f v=%b got=%b exp=%b", tag, v, f, e.f);
      end
      checks++;
      if (f_rise !== e.rise) begin
         errors++;
         $display("FAIL %s f_rise v=%b got=%b exp=%b", tag, v, f_rise, e.rise);
      end
      checks++;
      if (hit_cnt !== e.cnt) begin
         errors++;
         $display("FAIL %s hit_cnt v=%b got=%0d exp=%0d", tag, v, hit_cnt, e.cnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      {x1, x2, x3, x4} = 4'b1111;
      m_f   = 1'b0;
      m_cnt = 8'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({f, f_rise} !== 2'b00 || hit_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_state got f=%b rise=%b cnt=%0d exp 0 0 0", f, f_rise, hit_cnt);
      end
      checks++;
      if (f_comb !== 1'b1) begin
         errors++;
         $display("FAIL reset_fcomb got=%b exp=1", f_comb);
      end
      {x1, x2, x3, x4} = 4'b0000;
      #1;
      checks++;
      if (f_comb !== 1'b0) begin
         errors++;
         $display("FAIL reset_fcomb_follow got=%b exp=0", f_comb);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111, "release_hi");
      step(4'b1111, "release_hold");
      do_reset();
      step(4'b0000, "release_lo");
   endtask

   task automatic test_vectors();
      logic [3:0] vec [8];
      logic       exp [8];
      vec = '{4'b0000, 4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1011, 4'b1100, 4'b1111};
      exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(vec[i], "vec");
         checks++;
         if (f_comb !== exp[i]) begin
            errors++;
            $display("FAIL vec_table v=%b got=%b exp=%b", vec[i], f_comb, exp[i]);
         end
         step(vec[i], "vec_hold");
      end
   endtask

   task automatic test_rise();
      int pulses;
      logic [3:0] seq [5];
      seq = '{4'b0000, 4'b0011, 4'b0011, 4'b0000, 4'b1100};
      pulses = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(seq[i], "rise_seq");
         if (f_rise === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL rise_count got=%0d exp=2", pulses);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (5) step(4'b1111, "pre_async");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (f !== 1'b0 || f_rise !== 1'b0 || hit_cnt !== 8'd0) begin
         errors++;
         $display("FAIL async_reset got f=%b rise=%b cnt=%0d exp 0 0 0", f, f_rise, hit_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_f   = 1'b0;
      m_cnt = 8'd0;
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 300; i++) step(4'b1111, "sat");
      checks++;
      if (hit_cnt !== 8'd255) begin
         errors++;
         $display("FAIL sat_final got=%0d exp=255", hit_cnt);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (hit_cnt !== 8'd0 || f !== 1'b0) begin
         errors++;
         $display("FAIL sat_reset got cnt=%0d f=%b exp 0 0", hit_cnt, f);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_f   = 1'b0;
      m_cnt = 8'd0;
   endtask

   task automatic test_glitch();
      do_reset();
      step(4'b0000, "glitch_pre");
      step(4'b0000, "glitch_pre");
      #1;
      {x1, x2, x3, x4} = 4'b0011;
      #1;
      checks++;
      if (f_comb !== 1'b1) begin
         errors++;
         $display("FAIL glitch_fcomb got=%b exp=1", f_comb);
      end
      {x1, x2, x3, x4} = 4'b0000;
      #1;
      checks++;
      if (f_comb !== 1'b0) begin
         errors++;
         $display("FAIL glitch_fcomb_back got=%b exp=0", f_comb);
      end
      @(negedge clk);
      checks++;
      if (f !== 1'b0 || f_rise !== 1'b0 || hit_cnt !== m_cnt) begin
         errors++;
         $display("FAIL glitch_regs got f=%b rise=%b cnt=%0d exp 0 0 %0d", f, f_rise, hit_cnt, m_cnt);
      end
   endtask

   task automatic test_tt0001();
      logic [3:0] v;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         {x1, x2, x3, x4} = v;
         #1;
         checks++;
         if (f_comb1 !== (v == 4'd0)) begin
            errors++;
            $display("FAIL tt0001_fcomb v=%b got=%b exp=%b", v, f_comb1, (v == 4'd0));
         end
         @(negedge clk);
         checks++;
         if (f1 !== (v == 4'd0)) begin
            errors++;
            $display("FAIL tt0001_f v=%b got=%b exp=%b", v, f1, (v == 4'd0));
         end
      end
   endtask

   initial begin
      x1 = 1'b0; x2 = 1'b0; x3 = 1'b0; x4 = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_vectors();
      test_rise();
      test_async_reset();
      test_saturate();
      test_glitch();
      test_tt0001();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/example.md
EXAMPLE -- requirements
Module: example

Interface
REQ-001 Parameter TRUTH_TABLE, default 16'hF888, gives f for each input index {x1,x2,x3,x4}; bit i is the output for index i.
REQ-002 Parameter CNT_W, default 8, is the width of hit_cnt; legal range 1..32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 x1  input  1  function input, MSB of index.
REQ-006 x2  input  1  function input.
REQ-007 x3  input  1  function input.
REQ-008 x4  input  1  function input, LSB of index.
REQ-009 f_comb  output  1  combinational function value of the current inputs.
REQ-010 f  output  1  registered function value.
REQ-011 f_rise  output  1  one-cycle pulse on a 0->1 transition of f.
REQ-012 hit_cnt  output  CNT_W  saturating count of cycles with f=1.

Function
REQ-013 f_comb SHALL equal TRUTH_TABLE[{x1,x2,x3,x4}], with no clock involvement.
REQ-014 With default TRUTH_TABLE, f_comb SHALL equal (x1 AND x2) OR (x3 AND x4).
REQ-015 f SHALL take the value of f_comb sampled at each rising clk edge, giving 1-cycle latency.
REQ-016 f SHALL NOT react to input changes between clock edges; glitches on x1..x4 are invisible on f.
REQ-017 f_rise SHALL be registered and be 1 for exactly the cycle in which f changes from 0 to 1.
REQ-018 f_rise SHALL be 0 in all other cycles: f steady, f falling, and the first cycle after reset release when f stays 0.
REQ-019 hit_cnt SHALL increment by 1 on each rising edge where the new f value is 1.
REQ-020 hit_cnt SHALL hold at all-ones (255 at default) and SHALL NOT wrap.
REQ-021 X or Z on any input SHALL NOT be propagated into state; the synthesis-level behaviour follows the LUT index.

Reset
REQ-022 While rst_n=0, regardless of clk: f=0, f_rise=0, hit_cnt=0.
REQ-023 f_comb SHALL stay combinational during reset and follow the inputs.
REQ-024 Reset deassertion SHALL take effect at the next rising clk edge.
- On that edge f loads f_comb.
- If that value is 1, f_rise=1 and hit_cnt=1.
REQ-025 Reset asserted mid-operation SHALL immediately clear all registered outputs, including a saturated hit_cnt.

Structure
REQ-026 Package example_pkg SHALL hold:
- EXAMPLE_DEFAULT_TT = 16'hF888
- EXAMPLE_CNT_W_DEFAULT = 8
- a function idx4(x1,x2,x3,x4) returning the 4-bit index.
REQ-027 The combinational lookup SHALL live in one sub-module, example_lut.
- example_lut ports: idx[3:0], tt[15:0], y.
- example_lut has no state.
REQ-028 The top module SHALL contain only the f, f_rise and hit_cnt registers plus the saturation logic; there SHALL be no latches.

Verification
REQ-029 Apply the 8 vectors 0000, 0011, 0100, 0111, 1000, 1011, 1100, 1111, each held 2 cycles -> f_comb = 0,1,0,1,0,1,1,1, and f matches one cycle later.
REQ-030 Assert rst_n=0 mid-clock with f=1 and hit_cnt=5 -> f=0, f_rise=0, hit_cnt=0 immediately, without waiting for a clk edge.
REQ-031 Inputs sequence 0000 -> 0011 -> 0011 -> 0000 -> 1100 -> f_rise pulses high only in the cycles after the 0011 and 1100 edges.
REQ-032 Hold x=1111 for 300 cycles -> hit_cnt reaches 255 and stays at 255; no wrap.
REQ-033 Pulse an input to 0011 for less than one cycle, with no clk edge during the pulse -> f_comb pulses; f, f_rise and hit_cnt are unchanged.
REQ-034 Instantiate with TRUTH_TABLE=16'h0001 -> f_comb=1 only for input 0000; exhaustive sweep of all 16 input combinations matches.
